timer_counter_core: RTL and testbench

Parameterised up/down timer counter with programmable bounds, free-running mode and single-cycle terminal-count pulses. It is the counting core of the timer peripheral: the register block supplies the bounds and mode bits, and interrupt logic consumes `overflow_set` and `init`. The RTL module is named `timer_counter_core`.

---
 rtl/timer_counter_pkg.sv | 16 +
 rtl/timer_counter_tc.sv | 53 +++++
 rtl/timer_counter_core.sv | 78 +++++++
 tb/tb_timer_counter_core.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
//==============================================================================
// Module   : timer_counter_pkg
// Brief    : Shared constants for the timer counting core.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package timer_counter_pkg;

    localparam int   DEFAULT_COUNTER_SIZE = 8;
    localparam logic CNT_UP               = 1'b1;
    localparam logic CNT_DOWN             = 1'b0;

endpackage

`default_nettype wire

// File: rtl/timer_counter_tc.sv
//==============================================================================
// Module   : timer_counter_tc
// Brief    : Start-value selection and terminal-count detection.
//            Full-range mode present only with TIMER_COUNTER_FREE_EN defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_counter_tc
    import timer_counter_pkg::*;
#(
    parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE
) (
    input  logic [COUNTER_SIZE-1:0] value,
    input  logic [COUNTER_SIZE-1:0] min,
    input  logic [COUNTER_SIZE-1:0] max,
    input  logic                    cnt_mode,
    input  logic                    free,
    output logic [COUNTER_SIZE-1:0] start_val,
    output logic                    at_terminal
);

    logic                    w_up;
    logic [COUNTER_SIZE-1:0] w_bnd_start;
    logic                    w_bnd_term;

    assign w_up = (cnt_mode == CNT_UP);

    // Comparisons (not equality) so an out-of-range value recovers on the next enabled edge.
    assign w_bnd_start = w_up ? min : max;
    assign w_bnd_term  = w_up ? (value >= max) : (value <= min);

`ifdef TIMER_COUNTER_FREE_EN
    logic [COUNTER_SIZE-1:0] w_free_start;
    logic                    w_free_term;

    assign w_free_start = w_up ? {COUNTER_SIZE{1'b0}} : {COUNTER_SIZE{1'b1}};
    assign w_free_term  = w_up ? (value == {COUNTER_SIZE{1'b1}})
                               : (value == {COUNTER_SIZE{1'b0}});

    assign start_val   = free ? w_free_start : w_bnd_start;
    assign at_terminal = free ? w_free_term  : w_bnd_term;
`else
    logic w_unused_free;

    assign w_unused_free = free;
    assign start_val     = w_bnd_start;
    assign at_terminal   = w_bnd_term;
`endif

endmodule

`default_nettype wire

// File: rtl/timer_counter_core.sv
//==============================================================================
// Module   : timer_counter_core
// Brief    : Up/down timer counter with programmable bounds and one-cycle
//            reload/terminal pulses. Free-running mode: TIMER_COUNTER_FREE_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_counter_core
    import timer_counter_pkg::*;
#(
    parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    cnt_mode,
    input  logic [COUNTER_SIZE-1:0] min,
    input  logic [COUNTER_SIZE-1:0] max,
    input  logic                    free,
    input  logic                    init_cnt,
    output logic [COUNTER_SIZE-1:0] value,
    output logic                    init,
    output logic                    overflow_set
);

    localparam logic [COUNTER_SIZE-1:0] C_ONE = {{(COUNTER_SIZE-1){1'b0}}, 1'b1};

    logic [COUNTER_SIZE-1:0] r_value;
    logic                    r_init;
    logic                    r_overflow;
    logic [COUNTER_SIZE-1:0] w_start;
    logic                    w_at_term;

    timer_counter_tc #(
        .COUNTER_SIZE (COUNTER_SIZE)
    ) u_tc (
        .value       (r_value),
        .min         (min),
        .max         (max),
        .cnt_mode    (cnt_mode),
        .free        (free),
        .start_val   (w_start),
        .at_terminal (w_at_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value    <= {COUNTER_SIZE{1'b0}};
            r_init     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (init_cnt) begin
            r_value    <= w_start;
            r_init     <= 1'b1;
            r_overflow <= 1'b0;
        end else if (en) begin
            if (w_at_term) begin
                r_value    <= w_start;
                r_init     <= 1'b1;
                r_overflow <= 1'b1;
            end else begin
                r_value    <= (cnt_mode == CNT_UP) ? (r_value + C_ONE) : (r_value - C_ONE);
                r_init     <= 1'b0;
                r_overflow <= 1'b0;
            end
        end else begin
            r_init     <= 1'b0;
            r_overflow <= 1'b0;
        end
    end

    assign value        = r_value;
    assign init         = r_init;
    assign overflow_set = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_timer_counter_core.sv
//==============================================================================
// Module   : tb_timer_counter_core
// Brief    : Self-checking bench for timer_counter_core against an arithmetic
//            reference model; free-mode steps only with TIMER_COUNTER_FREE_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_timer_counter_core;

    localparam int W    = 8;
    localparam int FULL = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cnt_mode;
    logic [W-1:0] min_b;
    logic [W-1:0] max_b;
    logic         free_b;
    logic         init_cnt;
    logic [W-1:0] value;
    logic         init_o;
    logic         ovf_o;

    int checks   = 0;
    int failures = 0;

    int m_value = 0;
    int m_init  = 0;
    int m_ovf   = 0;

    timer_counter_core #(
        .COUNTER_SIZE (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cnt_mode     (cnt_mode),
        .min          (min_b),
        .max          (max_b),
        .free         (free_b),
        .init_cnt     (init_cnt),
        .value        (value),
        .init         (init_o),
        .overflow_set (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".value"},        32'(value),  32'(m_value));
        check({tag, ".init"},         32'(init_o), 32'(m_init));
        check({tag, ".overflow_set"}, 32'(ovf_o),  32'(m_ovf));
    endtask

    // Reference: start/terminal values from the mode table, then one edge of behaviour.
    task automatic tick(input string tag);
        int s;
        bit up, fr, term;
        up = cnt_mode;
        fr = 1'b0;
`ifdef TIMER_COUNTER_FREE_EN
        fr = free_b;
`endif
        if (fr) begin
            s    = up ? 0 : FULL;
            term = up ? (m_value == FULL) : (m_value == 0);
        end else begin
            s    = up ? int'(min_b) : int'(max_b);
            term = up ? (m_value >= int'(max_b)) : (m_value <= int'(min_b));
        end
        if (init_cnt) begin
            m_value = s; m_init = 1; m_ovf = 0;
        end else if (en) begin
            if (term) begin
                m_value = s; m_init = 1; m_ovf = 1;
            end else begin
                m_value = up ? (m_value + 1) % (FULL + 1) : (m_value + FULL) % (FULL + 1);
                m_init = 0; m_ovf = 0;
            end
        end else begin
            m_init = 0; m_ovf = 0;
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cnt_mode = 1'b1; min_b = '0; max_b = '0;
        free_b = 1'b0; init_cnt = 1'b0;
        #1;
        check("reset.value", 32'(value), 32'd0);
        check("reset.init",  32'(init_o), 32'd0);
        check("reset.ovf",   32'(ovf_o), 32'd0);
        @(posedge clk); #1;
        check_model("reset_edge");
        rst = 1'b0;

        // Up, bounds 0..1: 1,0,1,0 with pulses when value returns to 0
        en = 1'b1; cnt_mode = 1'b1; min_b = 8'd0; max_b = 8'd1;
        tick("up01_a");
        check("up01_first", 32'(value), 32'd1);
        tick("up01_b");
        check("up01_wrap_ovf", 32'(ovf_o), 32'd1);
        tick("up01_c");
        tick("up01_d");

        // Down 5..2 after preload
        cnt_mode = 1'b0; min_b = 8'd2; max_b = 8'd5; init_cnt = 1'b1;
        tick("down_load");
        init_cnt = 1'b0;
        for (int i = 0; i < 4; i++) tick("down_cnt");
        check("down_wrap_value", 32'(value), 32'd5);
        check("down_wrap_ovf",   32'(ovf_o), 32'd1);

`ifdef TIMER_COUNTER_FREE_EN
        free_b = 1'b1; cnt_mode = 1'b1; init_cnt = 1'b1;
        tick("free_load");
        init_cnt = 1'b0;
        for (int i = 0; i < 255; i++) tick("free_up");
        check("free_top", 32'(value), 32'd255);
        tick("free_up_wrap");
        check("free_up_wrap_ovf", 32'(ovf_o), 32'd1);
        cnt_mode = 1'b0;
        tick("free_down_wrap");
        check("free_down_wrap_value", 32'(value), 32'd255);
        free_b = 1'b0;
`endif

        // Reload with en low at value 7
        cnt_mode = 1'b1; min_b = 8'd0; max_b = 8'd20; init_cnt = 1'b1;
        tick("ld0");
        init_cnt = 1'b0;
        for (int i = 0; i < 7; i++) tick("to7");
        check("at7", 32'(value), 32'd7);
        en = 1'b0; min_b = 8'd3; init_cnt = 1'b1;
        tick("reload_en0");
        check("reload_value", 32'(value), 32'd3);
        check("reload_ovf",   32'(ovf_o), 32'd0);
        init_cnt = 1'b0;

        // Enable low for three cycles mid-count
        en = 1'b1;
        tick("pre_hold");
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold");
        check("hold_value", 32'(value), 32'd4);

        // Asynchronous reset between edges at value 4
        en = 1'b1; min_b = 8'd0; init_cnt = 1'b1;
        tick("ar_load");
        init_cnt = 1'b0;
        for (int i = 0; i < 4; i++) tick("ar_cnt");
        #2 rst = 1'b1;
        #1;
        check("async_rst_value", 32'(value), 32'd0);
        check("async_rst_init",  32'(init_o), 32'd0);
        m_value = 0; m_init = 0; m_ovf = 0;
        @(negedge clk);
        rst = 1'b0;

        // min == max: every enabled edge is terminal
        min_b = 8'd9; max_b = 8'd9; init_cnt = 1'b1;
        tick("eq_load");
        init_cnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("eq_run");
            check("eq_ovf_held", 32'(ovf_o), 32'd1);
        end

        // min > max in up mode: reloads to min on each enabled edge
        min_b = 8'd12; max_b = 8'd4;
        for (int i = 0; i < 3; i++) tick("inv_up");
        check("inv_up_value", 32'(value), 32'd12);

        // Randomised run against the model
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            cnt_mode = 1'($urandom_range(0, 1));
            min_b    = 8'($urandom_range(0, 20));
            max_b    = 8'($urandom_range(0, 20));
            free_b   = ($urandom_range(0, 7) == 0);
            init_cnt = ($urandom_range(0, 15) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
